operand_launch_ctrl: RTL and testbench

Fabric-side sequencer between the HPS operand PIOs (64-bit `operand_a`/`operand_b` exports) and a multi-cycle arithmetic datapath whose output feeds the 64-bit `result` PIO. It detects new operand values written by software, waits for them to settle (a 64-bit PIO is written as two 32-bit bus writes), snapshots them, and launches the datapath with a start/done handshake. It then captures the result and reports busy, valid and timeout status. All signals are in the `clk_clk` domain; no CDC inside.

---
 rtl/operand_launch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_operand_launch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_launch_ctrl.sv
// Operand launch sequencer: settles software-written operands, launches the datapath, captures result.
// Optional WAIT timeout is built when OPERAND_LAUNCH_CTRL_TIMEOUT_EN is defined.
module operand_launch_ctrl #(
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] operand_a_in,
    input  logic [DATA_W-1:0] operand_b_in,
    output logic [DATA_W-1:0] dp_operand_a,
    output logic [DATA_W-1:0] dp_operand_b,
    output logic              dp_start,
    input  logic              dp_done,
    input  logic [DATA_W-1:0] dp_result,
    output logic [DATA_W-1:0] result_out,
    output logic              busy,
    output logic              result_valid,
    output logic              timeout_err
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_err
        $error("operand_launch_ctrl: SETTLE_CYCLES or TIMEOUT_CYCLES out of range");
    end

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StLaunch, StWait} state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [2*DATA_W-1:0]   r_sample;
    logic [2*DATA_W-1:0]   r_shadow;
    logic [7:0]            r_settle_cnt;
    logic [DATA_W-1:0]     r_dp_a;
    logic [DATA_W-1:0]     r_dp_b;
    logic [DATA_W-1:0]     r_result;
    logic                  r_result_valid;

    logic [2*DATA_W-1:0]   w_inputs;
    logic                  w_sample_load;
    logic                  w_settle_inc;
    logic                  w_launch;
    logic                  w_done_cap;
    logic                  w_timeout_hit;
    logic                  w_wait_inc;

    assign w_inputs = {operand_a_in, operand_b_in};

`ifdef OPERAND_LAUNCH_CTRL_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_wait_cnt;
    logic        r_timeout_err;
    wire         w_wait_expired = (r_wait_cnt == WAIT_LAST);
`else
    wire         w_wait_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_sample_load = 1'b0;
        w_settle_inc  = 1'b0;
        w_launch      = 1'b0;
        w_done_cap    = 1'b0;
        w_timeout_hit = 1'b0;
        w_wait_inc    = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_inputs != r_shadow) begin
                    w_sample_load = 1'b1;
                    w_state_d     = StSettle;
                end
            end
            StSettle: begin
                if (w_inputs != r_sample) begin
                    w_sample_load = 1'b1;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_launch  = 1'b1;
                    w_state_d = StLaunch;
                end else begin
                    w_settle_inc = 1'b1;
                end
            end
            StLaunch: w_state_d = StWait;
            StWait: begin
                // Done takes priority over a coincident timeout.
                if (dp_done) begin
                    w_done_cap = 1'b1;
                    w_state_d  = StIdle;
                end else if (w_wait_expired) begin
                    w_timeout_hit = 1'b1;
                    w_state_d     = StIdle;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample       <= '0;
            r_shadow       <= '0;
            r_settle_cnt   <= '0;
            r_dp_a         <= '0;
            r_dp_b         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            if (w_sample_load) begin
                r_sample     <= w_inputs;
                r_settle_cnt <= '0;
            end else if (w_settle_inc) begin
                r_settle_cnt <= r_settle_cnt + 8'd1;
            end
            // Valid clears on entry to LAUNCH so it is already low while dp_start is high.
            if (w_launch) begin
                r_dp_a         <= r_sample[2*DATA_W-1:DATA_W];
                r_dp_b         <= r_sample[DATA_W-1:0];
                r_shadow       <= r_sample;
                r_result_valid <= 1'b0;
            end
            if (w_done_cap) begin
                r_result       <= dp_result;
                r_result_valid <= 1'b1;
            end
        end
    end

`ifdef OPERAND_LAUNCH_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == StLaunch) begin
                r_wait_cnt <= '0;
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_launch) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    assign dp_start     = (r_state == StLaunch);
    assign busy         = (r_state != StIdle);
    assign dp_operand_a = r_dp_a;
    assign dp_operand_b = r_dp_b;
    assign result_out   = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_operand_launch_ctrl.sv
// Directed bench for operand_launch_ctrl (SETTLE_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_operand_launch_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] op_a, op_b, dp_result, dp_operand_a, dp_operand_b, result_out;
    logic        dp_start, dp_done, busy, result_valid, timeout_err;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    operand_launch_ctrl #(
        .DATA_W         (64),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .operand_a_in (op_a),
        .operand_b_in (op_b),
        .dp_operand_a (dp_operand_a),
        .dp_operand_b (dp_operand_b),
        .dp_start     (dp_start),
        .dp_done      (dp_done),
        .dp_result    (dp_result),
        .result_out   (result_out),
        .busy         (busy),
        .result_valid (result_valid),
        .timeout_err  (timeout_err)
    );

    // Counts negedges until dp_start is seen high (bounded at 100).
    task automatic wait_start(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (dp_start !== 1'b1 && cycles < 100);
    endtask

    task automatic test_reset();
        logic        any_start;
        logic [2:0]  flags;
        logic [63:0] acc;
        reset_n = 1'b1; op_a = '0; op_b = '0; dp_done = 1'b0; dp_result = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({dp_start, busy, result_valid, timeout_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {dp_start, busy, result_valid, timeout_err});
        end
        n_cmp++;
        if ((dp_operand_a | dp_operand_b | result_out) !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", dp_operand_a | dp_operand_b | result_out);
        end
        reset_n = 1'b1;
        any_start = 1'b0; flags = '0; acc = '0;
        repeat (50) begin
            @(negedge clk);
            any_start |= dp_start;
            flags     |= {busy, result_valid, timeout_err};
            acc       |= dp_operand_a | dp_operand_b | result_out;
        end
        n_cmp++;
        if (any_start !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_start: got %b want 0", any_start);
        end
        n_cmp++;
        if (flags !== 3'b0) begin
            n_fail++; $display("FAIL idle_flags: got %b want 000", flags);
        end
        n_cmp++;
        if (acc !== 64'h0) begin
            n_fail++; $display("FAIL idle_data: got %h want 0", acc);
        end
    endtask

    task automatic test_basic_launch();
        int cycles;
        op_a = 64'd5; op_b = 64'd7;
        wait_start(cycles);
        n_cmp++;
        if (cycles !== 5) begin
            n_fail++; $display("FAIL basic_latency: got %0d want 5", cycles);
        end
        n_cmp++;
        if ({dp_operand_a, dp_operand_b} !== {64'd5, 64'd7}) begin
            n_fail++;
            $display("FAIL basic_operands: got %0d/%0d want 5/7", dp_operand_a, dp_operand_b);
        end
        @(negedge clk);
        n_cmp++;
        if (dp_start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pulse_width: got start=%b busy=%b want 0/1", dp_start, busy);
        end
        @(negedge clk);
        @(negedge clk);
        dp_done = 1'b1; dp_result = 64'd35;
        @(negedge clk);
        dp_done = 1'b0; dp_result = '0;
        n_cmp++;
        if ({result_out, result_valid, busy} !== {64'd35, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: got %0d v=%b b=%b want 35 v=1 b=0",
                     result_out, result_valid, busy);
        end
    endtask

    task automatic test_split_write();
        int cycles;
        int extra;
        extra = 0;
        op_a = 64'h0000_0000_0000_0001;
        repeat (2) begin
            @(negedge clk);
            if (dp_start === 1'b1) extra++;
        end
        op_a = 64'h0000_0002_0000_0001;
        wait_start(cycles);
        n_cmp++;
        if (cycles !== 5) begin
            n_fail++; $display("FAIL split_latency: got %0d want 5", cycles);
        end
        n_cmp++;
        if (dp_operand_a !== 64'h0000_0002_0000_0001) begin
            n_fail++;
            $display("FAIL split_operand_a: got %h want 0000000200000001", dp_operand_a);
        end
        @(negedge clk);
        dp_done = 1'b1; dp_result = 64'hABCD;
        @(negedge clk);
        dp_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (dp_start === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++; $display("FAIL split_single_start: got %0d extra want 0", extra);
        end
    endtask

    task automatic test_change_while_busy();
        int cycles;
        op_b = 64'd3;
        wait_start(cycles);
        @(negedge clk);
        op_b = 64'd9;
        @(negedge clk);
        dp_done = 1'b1; dp_result = 64'd100;
        @(negedge clk);
        dp_done = 1'b0;
        n_cmp++;
        if ({result_out, result_valid, busy} !== {64'd100, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL busy_first_result: got %0d v=%b b=%b want 100 v=1 b=0",
                     result_out, result_valid, busy);
        end
        wait_start(cycles);
        n_cmp++;
        if (cycles !== 5) begin
            n_fail++; $display("FAIL busy_relaunch_latency: got %0d want 5", cycles);
        end
        n_cmp++;
        if (dp_operand_b !== 64'd9 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_relaunch: got b=%0d v=%b want b=9 v=0", dp_operand_b, result_valid);
        end
        @(negedge clk);
        dp_done = 1'b1; dp_result = 64'd200;
        @(negedge clk);
        dp_done = 1'b0;
    endtask

    task automatic test_timeout();
        int cycles;
        op_b = 64'd11;
        wait_start(cycles);
`ifdef OPERAND_LAUNCH_CTRL_TIMEOUT_EN
        repeat (T) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got b=%b t=%b want b=1 t=0", busy, timeout_err);
        end
        @(negedge clk);
        n_cmp++;
        if ({timeout_err, busy, result_valid, result_out} !== {1'b1, 1'b0, 1'b0, 64'd200}) begin
            n_fail++;
            $display("FAIL timeout_fire: got t=%b b=%b v=%b r=%0d want t=1 b=0 v=0 r=200",
                     timeout_err, busy, result_valid, result_out);
        end
        dp_done = 1'b1; dp_result = 64'hDEAD;
        @(negedge clk);
        dp_done = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({timeout_err, busy, result_valid, result_out} !== {1'b1, 1'b0, 1'b0, 64'd200}) begin
            n_fail++;
            $display("FAIL timeout_stray_done: got t=%b b=%b v=%b r=%0d want t=1 b=0 v=0 r=200",
                     timeout_err, busy, result_valid, result_out);
        end
`else
        repeat (40) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_forever: got b=%b t=%b want b=1 t=0", busy, timeout_err);
        end
        dp_done = 1'b1; dp_result = 64'h55;
        @(negedge clk);
        dp_done = 1'b0;
        n_cmp++;
        if ({result_out, result_valid, busy} !== {64'h55, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL late_done: got %h v=%b b=%b want 55 v=1 b=0",
                     result_out, result_valid, busy);
        end
        dp_done = 1'b1; dp_result = 64'hDEAD;
        @(negedge clk);
        dp_done = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({result_out, result_valid, busy} !== {64'h55, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL stray_done: got %h v=%b b=%b want 55 v=1 b=0",
                     result_out, result_valid, busy);
        end
`endif
    endtask

    task automatic test_done_at_timeout();
        int cycles;
        op_b = 64'd13;
        wait_start(cycles);
        repeat (T) @(negedge clk);
        dp_done = 1'b1; dp_result = 64'h77;
        @(negedge clk);
        dp_done = 1'b0;
        n_cmp++;
        if ({result_out, result_valid, timeout_err, busy} !== {64'h77, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL done_vs_timeout: got %h v=%b t=%b b=%b want 77 v=1 t=0 b=0",
                     result_out, result_valid, timeout_err, busy);
        end
    endtask

    task automatic test_reset_mid();
        int         cycles;
        logic       any_start;
        logic [2:0] flags;
        op_b = 64'd15;
        wait_start(cycles);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({dp_start, busy, result_valid, timeout_err} !== 4'b0 ||
            (dp_operand_a | dp_operand_b | result_out) !== 64'h0) begin
            n_fail++;
            $display("FAIL async_reset: got flags=%b data=%h want 0",
                     {dp_start, busy, result_valid, timeout_err},
                     dp_operand_a | dp_operand_b | result_out);
        end
        op_a = '0; op_b = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        dp_done = 1'b1; dp_result = 64'h99;
        @(negedge clk);
        dp_done = 1'b0;
        any_start = 1'b0; flags = '0;
        repeat (5) begin
            @(negedge clk);
            any_start |= dp_start;
            flags     |= {busy, result_valid, timeout_err};
        end
        n_cmp++;
        if ({any_start, flags} !== 4'b0 || result_out !== 64'h0) begin
            n_fail++;
            $display("FAIL post_reset_done: got s=%b flags=%b r=%h want 0",
                     any_start, flags, result_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic_launch();
        test_split_write();
        test_change_while_busy();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
